// File: rtl/mcalu_arbiter.sv
// mcalu_arbiter: round-robin sharing of one multi-cycle ALU (start/done
// handshake) among NREQ requesters. Opcodes 8..15 are rejected locally.
// Optional one-entry result cache enabled by defining MCALU_ARB_CACHE_EN.
module mcalu_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ*4-1:0]    req_opcode,
  output logic [NREQ-1:0]      resp_done,
  output logic [31:0]          resp_y,
  output logic                 resp_err,
  output logic                 alu_start,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [3:0]           alu_opcode,
  input  logic                 alu_done,
  input  logic [31:0]          alu_y
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RELEASE} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n, owner, owner_n, win;
  logic            found;
  int              idx;
  logic [31:0]     w_a, w_b;
  logic [3:0]      w_op;
  logic [NREQ-1:0] done_n;
  logic [31:0]     y_n, a_n, b_n;
  logic            err_n, start_n;
  logic [3:0]      op_n;
  logic            c_hit;

`ifdef MCALU_ARB_CACHE_EN
  logic        c_valid;
  logic [3:0]  c_op;
  logic [31:0] c_a, c_b, c_y;

  // Remember the last ALU completion; lookups compare the winner's operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_valid <= 1'b0;
      c_op    <= '0;
      c_a     <= '0;
      c_b     <= '0;
      c_y     <= '0;
    end else if (state == S_WAIT && alu_done) begin
      c_valid <= 1'b1;
      c_op    <= alu_opcode;
      c_a     <= alu_a;
      c_b     <= alu_b;
      c_y     <= alu_y;
    end
  end

  assign c_hit = c_valid && !w_op[3] && (w_op == c_op) && (w_a == c_a) && (w_b == c_b);
`else
  assign c_hit = 1'b0;
`endif

  // Round-robin search: first pending requester at or after ptr.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign w_a  = req_a[32*int'(win) +: 32];
  assign w_b  = req_b[32*int'(win) +: 32];
  assign w_op = req_opcode[4*int'(win) +: 4];

  // Next-state and next-output logic; all outputs are registered.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    done_n  = '0;
    y_n     = resp_y;
    err_n   = resp_err;
    start_n = 1'b0;
    a_n     = alu_a;
    b_n     = alu_b;
    op_n    = alu_opcode;
    case (state)
      S_IDLE: begin
        if (found) begin
          owner_n = win;
          ptr_n   = IW'((int'(win) + 1) % NREQ);
          if (w_op[3]) begin
            // Unimplemented opcode: answer locally, never touch the ALU.
            y_n         = '0;
            err_n       = 1'b1;
            done_n[win] = 1'b1;
            state_n     = S_RELEASE;
          end else if (c_hit) begin
            y_n         = c_y_or_zero();
            err_n       = 1'b0;
            done_n[win] = 1'b1;
            state_n     = S_RELEASE;
          end else begin
            a_n     = w_a;
            b_n     = w_b;
            op_n    = w_op;
            start_n = 1'b1;
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (alu_done) begin
          y_n           = alu_y;
          err_n         = 1'b0;
          done_n[owner] = 1'b1;
          state_n       = S_RELEASE;
        end
      end
      S_RELEASE: state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // Cached result, or zero when the cache is not built in (never selected then).
  function automatic logic [31:0] c_y_or_zero();
`ifdef MCALU_ARB_CACHE_EN
    return c_y;
`else
    return 32'd0;
`endif
  endfunction

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      owner      <= '0;
      resp_done  <= '0;
      resp_y     <= '0;
      resp_err   <= 1'b0;
      alu_start  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      owner      <= owner_n;
      resp_done  <= done_n;
      resp_y     <= y_n;
      resp_err   <= err_n;
      alu_start  <= start_n;
      alu_a      <= a_n;
      alu_b      <= b_n;
      alu_opcode <= op_n;
    end
  end
endmodule

// File: tb/tb_mcalu_arbiter.sv
// tb_mcalu_arbiter: directed vectors against mcalu_arbiter (NREQ=2) with a
// small fixed-latency ALU responder. Cache cases follow MCALU_ARB_CACHE_EN.
module tb_mcalu_arbiter;
  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*32-1:0] req_a, req_b;
  logic [NREQ*4-1:0] req_opcode;
  logic [NREQ-1:0]   resp_done;
  logic [31:0]       resp_y;
  logic              resp_err;
  logic              alu_start;
  logic [31:0]       alu_a, alu_b;
  logic [3:0]        alu_opcode;
  logic              alu_done, alu_done_m, spur;
  logic [31:0]       alu_y;

  int n_chk = 0, n_fail = 0;
  int start_cnt = 0, done_cnt = 0;
  int alu_cnt = 0;

  // Results of the last transaction
  logic [NREQ-1:0] got_d;
  logic [31:0]     got_y;
  logic            got_err, got_prev_ad, got_ok;
  int              got_cyc, s0;

  mcalu_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_opcode(req_opcode), .resp_done(resp_done), .resp_y(resp_y), .resp_err(resp_err),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_done(alu_done), .alu_y(alu_y)
  );

  always #5 clk = ~clk;

  assign alu_done = alu_done_m | spur;

  // ALU stand-in: result 3 edges after the start pulse is sampled
  always @(posedge clk) begin
    alu_done_m <= 1'b0;
    if (reset) begin
      alu_cnt <= 0;
      alu_y   <= '0;
    end else if (alu_start) begin
      alu_cnt <= 3;
      case (alu_opcode)
        4'd0, 4'd1: alu_y <= alu_a * alu_b;
        4'd4:       alu_y <= (alu_b != 0) ? alu_a / alu_b : 32'hFFFF_FFFF;
        4'd6:       alu_y <= (alu_b != 0) ? alu_a % alu_b : alu_a;
        default:    alu_y <= 32'd0;
      endcase
    end else if (alu_cnt > 0) begin
      alu_cnt    <= alu_cnt - 1;
      alu_done_m <= (alu_cnt == 1);
    end
  end

  // Event counters
  always @(posedge clk) begin
    if (alu_start) start_cnt <= start_cnt + 1;
    if (|resp_done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Wait (bounded) for a completion pulse; record result and whether
  // alu_done was high just before that edge.
  task automatic wait_done();
    logic prev;
    got_ok = 1'b0;
    got_cyc = 0;
    prev = alu_done;
    while (!got_ok && got_cyc < 100) begin
      tick();
      if (|resp_done) begin
        got_ok = 1'b1;
        got_d = resp_done;
        got_y = resp_y;
        got_err = resp_err;
        got_prev_ad = prev;
      end else begin
        got_cyc++;
      end
      prev = alu_done;
    end
    if (!got_ok) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32]     = a;
    req_b[32*i +: 32]     = b;
    req_opcode[4*i +: 4]  = op;
    req_valid[i]          = 1'b1;
  endtask

  // Full transaction on one requester; owner drops after the done pulse.
  task automatic txn(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    s0 = start_cnt;
    set_req(i, op, a, b);
    wait_done();
    req_valid[i] = 1'b0;
    tick(); tick();
  endtask

  initial begin
    req_a = '0; req_b = '0; req_opcode = '0; req_valid = '0; spur = 1'b0;
    do_reset();

    // Reset state
    chk("rst_done",  resp_done, 0);
    chk("rst_y",     resp_y, 0);
    chk("rst_err",   resp_err, 0);
    chk("rst_start", alu_start, 0);
    chk("rst_a",     alu_a, 0);
    chk("rst_op",    alu_opcode, 0);

    // Single request, multu 7*6, owner holds req one cycle past done
    s0 = start_cnt;
    set_req(0, 4'd1, 32'd7, 32'd6);
    tick();
    chk("t1_start_lat", alu_start, 1);
    chk("t1_alu_a", alu_a, 7);
    chk("t1_alu_b", alu_b, 6);
    wait_done();
    chk("t1_done", got_d, 2'b01);
    chk("t1_y", got_y, 42);
    chk("t1_err", got_err, 0);
    chk("t1_lat", got_prev_ad, 1);
    tick();
    chk("t1_pulse", resp_done, 0);
    req_valid[0] = 1'b0;
    repeat (6) tick();
    chk("t1_one_start", start_cnt - s0, 1);
    chk("t1_one_done", done_cnt, 1);

    // Simultaneous requests after reset, 100/7
    do_reset();
    set_req(0, 4'd4, 32'd100, 32'd7);
    set_req(1, 4'd4, 32'd100, 32'd7);
    req_a[63:32] = 32'd100;
    wait_done();
    chk("t2_first", got_d, 2'b01);
    chk("t2_y0", got_y, 14);
    req_valid[0] = 1'b0;
    wait_done();
    chk("t2_second", got_d, 2'b10);
    chk("t2_y1", got_y, 14);
    req_valid[1] = 1'b0;
    tick();
    chk("t2_ptr", dut.ptr, 0);

    // Rejected opcode on requester 1
    s0 = start_cnt;
    set_req(1, 4'd9, 32'd3, 32'd4);
    tick();
    chk("t3_done", resp_done, 2'b10);
    chk("t3_y", resp_y, 0);
    chk("t3_err", resp_err, 1);
    req_valid[1] = 1'b0;
    repeat (4) tick();
    chk("t3_no_start", start_cnt - s0, 0);

    // Spurious alu_done in IDLE is ignored
    spur = 1'b1; tick(); spur = 1'b0; tick();
    chk("spur_done", resp_done, 0);
    chk("spur_y", resp_y, 0);

    // Reset during WAIT of a divide
    set_req(0, 4'd4, 32'd50, 32'd5);
    tick();
    chk("t4_start", alu_start, 1);
    tick();
    reset = 1'b1;
    req_valid = '0;
    tick();
    reset = 1'b0;
    chk("t4_rst_done", resp_done, 0);
    chk("t4_rst_y", resp_y, 0);
    chk("t4_rst_err", resp_err, 0);
    chk("t4_rst_aa", alu_a, 0);
    s0 = done_cnt;
    repeat (6) tick();
    chk("t4_no_pulse", done_cnt - s0, 0);
    txn(0, 4'd6, 32'd50, 32'd7);
    chk("t4_after_y", got_y, 1);
    chk("t4_after_d", got_d, 2'b01);

    // Cache behaviour: repeated signed multiply -3*5
    txn(0, 4'd0, 32'hFFFF_FFFD, 32'd5);
    chk("t5_first_y", got_y, 32'hFFFF_FFF1);
    chk("t5_first_start", start_cnt - s0, 1);
    txn(0, 4'd0, 32'hFFFF_FFFD, 32'd5);
    chk("t5_rep_y", got_y, 32'hFFFF_FFF1);
`ifdef MCALU_ARB_CACHE_EN
    chk("t5_rep_start", start_cnt - s0, 0);
    chk("t5_rep_lat", got_cyc, 0);
`else
    chk("t5_rep_start", start_cnt - s0, 1);
`endif
    txn(0, 4'd1, 32'hFFFF_FFFD, 32'd5);
    chk("t5_op1_y", got_y, 32'hFFFF_FFF1);
    chk("t5_op1_start", start_cnt - s0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
